// File: rtl/genpipe_adder_if.sv
// Handshake bundle for genpipe_adder: operand side (in_*) and result side (out_*).
// The adder takes the slave modport; the producer/consumer takes master.
interface genpipe_adder_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_sub;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
    logic             out_ovf;

    modport slave (
        input  in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout, out_ovf
    );

    modport master (
        output in_valid, in_a, in_b, in_sub, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout, out_ovf
    );
endinterface

// File: rtl/genpipe_adder.sv
// Pipelined add/subtract: one SEG-bit segment per stage, carry registered between stages.
// Each stage keeps only the completed low sum bits and the not-yet-consumed operand bits.
module genpipe_adder #(
    parameter int WIDTH = 8,
    parameter int SEG   = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    genpipe_adder_if.slave  bus
);
    localparam int NSTAGES = (SEG > 0) ? (WIDTH / SEG) : 1;

    if (WIDTH < 1 || SEG < 1 || SEG > WIDTH || (WIDTH % SEG) != 0) begin : g_param_check
        $error("genpipe_adder: SEG must divide WIDTH exactly (WIDTH=%0d SEG=%0d)", WIDTH, SEG);
    end

    // Ripple one segment; returns {carry_out, sum}.
    function automatic logic [SEG:0] seg_add(
        input logic [SEG-1:0] a,
        input logic [SEG-1:0] b,
        input logic           ci
    );
        logic           c;
        logic [SEG-1:0] s;
        c = ci;
        s = {SEG{1'b0}};
        for (int i = 0; i < SEG; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (a[i] & c) | (b[i] & c);
        end
        return {c, s};
    endfunction

    for (genvar k = 0; k < NSTAGES; k++) begin : g_stage
        localparam int SW = WIDTH - k * SEG;        // operand bits still to consume
        localparam int LW = (k + 1) * SEG;          // sum bits complete after this stage

        logic          r_valid;
        logic          r_carry;
        logic [LW-1:0] r_sum;

        logic          w_adv;
        logic          w_src_valid;
        logic          w_src_carry;
        logic [SW-1:0] w_src_a;
        logic [SW-1:0] w_src_b;
        logic [SEG:0]  w_seg;
        logic [LW-1:0] w_nxt_sum;

        if (k == NSTAGES - 1) begin : g_adv_last
            assign w_adv = !r_valid | bus.out_ready;
        end else begin : g_adv_mid
            assign w_adv = !r_valid | g_stage[k+1].w_adv;
        end

        if (k == 0) begin : g_src_in
            assign w_src_valid = bus.in_valid;
            assign w_src_a     = bus.in_a;
            assign w_src_b     = bus.in_sub ? ~bus.in_b : bus.in_b;
            assign w_src_carry = bus.in_sub ? 1'b1 : bus.in_cin;
            assign w_nxt_sum   = w_seg[SEG-1:0];
        end else begin : g_src_prev
            assign w_src_valid = g_stage[k-1].r_valid;
            assign w_src_a     = g_stage[k-1].g_fwd.r_a_hi;
            assign w_src_b     = g_stage[k-1].g_fwd.r_b_hi;
            assign w_src_carry = g_stage[k-1].r_carry;
            assign w_nxt_sum   = {w_seg[SEG-1:0], g_stage[k-1].r_sum};
        end

        assign w_seg = seg_add(w_src_a[SEG-1:0], w_src_b[SEG-1:0], w_src_carry);

        // Stage core: valid, carry and completed sum bits; data only moves with a valid entry.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_valid <= 1'b0;
                r_carry <= 1'b0;
                r_sum   <= {LW{1'b0}};
            end else if (w_adv) begin
                r_valid <= w_src_valid;
                if (w_src_valid) begin
                    r_carry <= w_seg[SEG];
                    r_sum   <= w_nxt_sum;
                end
            end
        end

        if (k < NSTAGES - 1) begin : g_fwd
            logic [SW-SEG-1:0] r_a_hi;
            logic [SW-SEG-1:0] r_b_hi;

            // Operand bits above this segment travel forward for the later stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_a_hi <= {(SW-SEG){1'b0}};
                    r_b_hi <= {(SW-SEG){1'b0}};
                end else if (w_adv && w_src_valid) begin
                    r_a_hi <= w_src_a[SW-1:SEG];
                    r_b_hi <= w_src_b[SW-1:SEG];
                end
            end
        end else begin : g_tail
            logic r_ovf;

            // Same-sign operands (B already inverted for sub) yielding an opposite-sign
            // MSB is exactly carry-into-MSB xor carry-out-of-MSB.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_ovf <= 1'b0;
                end else if (w_adv && w_src_valid) begin
                    r_ovf <= (w_src_a[SEG-1] ~^ w_src_b[SEG-1]) & (w_seg[SEG-1] ^ w_src_a[SEG-1]);
                end
            end
        end
    end

    assign bus.in_ready  = g_stage[0].w_adv;
    assign bus.out_valid = g_stage[NSTAGES-1].r_valid;
    assign bus.out_sum   = g_stage[NSTAGES-1].r_sum;
    assign bus.out_cout  = g_stage[NSTAGES-1].r_carry;
    assign bus.out_ovf   = g_stage[NSTAGES-1].g_tail.r_ovf;
endmodule
